// File: rtl/dkong_vram_arbiter_if.sv
`timescale 1ns/1ps
// CPU-side VRAM bus: level request with access attributes, read data, ACK pulse and stall line.
// The CPU side drives through the master modport; the arbiter answers through the slave modport.
interface dkong_vram_arbiter_if;
  logic       req;
  logic       we;
  logic [9:0] ab;
  logic [7:0] db;
  logic [7:0] q;
  logic       ack;
  logic       waitn;

  modport master (
    output req, we, ab, db,
    input  q, ack, waitn
  );

  modport slave (
    input  req, we, ab, db,
    output q, ack, waitn
  );
endinterface

// File: rtl/dkong_vram_arbiter.sv
`timescale 1ns/1ps
// Owns the 1024x8 tile VRAM: post-reset fill, video fetch priority, one CPU slot per character.
// CPU access: same-clock capture, wait for slot, 1-clock RAM cycle, ACK pulse; CPU stalled via waitn.
module dkong_vram_arbiter #(
  parameter logic [7:0] FILL_VAL     = 8'h10,
  parameter bit         CLR_ON_RESET = 1'b1,
  parameter logic [2:0] CPU_SLOT     = 3'b100
) (
  input  logic                 CLK_24M,
  input  logic                 I_RESET,
  input  logic                 CLK_EN,
  input  logic [9:0]           I_H_CNT,
  input  logic [7:0]           I_VF_CNT,
  input  logic                 I_FLIP,
  input  logic                 I_CMPBLK,
  dkong_vram_arbiter_if.slave  cpu,
  output logic [9:0]           O_RAM_AB,
  output logic [7:0]           O_RAM_D,
  output logic                 O_RAM_CE,
  output logic                 O_RAM_WE,
  input  logic [7:0]           I_RAM_Q,
  output logic                 O_CLR_BUSY
);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_PEND,
    ST_ACCESS,
    ST_DONE
  } state_t;

  localparam state_t RST_STATE = CLR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t     state;
  state_t     state_nxt;
  logic [9:0] clr_cnt;
  logic       armed;
  logic       lat_we;
  logic [9:0] lat_ab;
  logic [7:0] lat_db;
  logic [7:0] cpu_q;

  logic       capture;
  logic       slot_open;
  logic [9:0] video_ab;
  logic [9:0] ram_ab;
  logic [7:0] ram_d;
  logic       ram_we;
  logic       unused_cnt_bits;

  // armed drops on ACK and re-arms only once REQ has been seen low: one held REQ, one access
  assign capture   = (state == ST_IDLE) && cpu.req && armed;
  assign slot_open = CLK_EN && (!I_CMPBLK || (I_H_CNT[3:1] == CPU_SLOT));
  assign video_ab  = {I_VF_CNT[7:3], I_H_CNT[8:4] ^ {5{I_FLIP}}};

  always_ff @(posedge CLK_24M) begin
    if (I_RESET) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
      armed   <= 1'b1;
      lat_we  <= 1'b0;
      lat_ab  <= '0;
      lat_db  <= '0;
      cpu_q   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_CLEAR) && CLK_EN)
        clr_cnt <= clr_cnt + 10'd1;
      if (capture) begin
        lat_we <= cpu.we;
        lat_ab <= cpu.ab;
        lat_db <= cpu.db;
      end
      if ((state == ST_ACCESS) && !lat_we)
        cpu_q <= I_RAM_Q;
      if (state == ST_DONE)
        armed <= 1'b0;
      else if (!cpu.req)
        armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_ab    = video_ab;
    ram_d     = '0;
    ram_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        ram_ab = clr_cnt;
        ram_d  = FILL_VAL;
        ram_we = CLK_EN;
        if (CLK_EN && (clr_cnt == 10'h3FF))
          state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (capture)
          state_nxt = ST_PEND;
      end
      // The grant clock: RAM sees the CPU address for exactly this one clock
      ST_PEND: begin
        if (slot_open) begin
          ram_ab    = lat_ab;
          ram_d     = lat_db;
          ram_we    = lat_we;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = RST_STATE;
    endcase
  end

  // Reset gates the write strobe so an in-flight grant or clear write never lands
  assign O_RAM_AB   = ram_ab;
  assign O_RAM_D    = ram_d;
  assign O_RAM_WE   = ram_we && !I_RESET;
  assign O_RAM_CE   = 1'b1;
  assign O_CLR_BUSY = I_RESET ? CLR_ON_RESET : (state == ST_CLEAR);

  assign cpu.q     = cpu_q;
  assign cpu.ack   = !I_RESET && (state == ST_DONE);
  assign cpu.waitn = I_RESET || !((state == ST_CLEAR) || (state == ST_PEND) ||
                                  (state == ST_ACCESS) || capture);

  assign unused_cnt_bits = ^{I_H_CNT[9], I_H_CNT[0], I_VF_CNT[2:0]};

endmodule
